// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: groups the request, response and memory-port signals of
// mem_access_unit.
//   slave  : the unit's view. It takes requests, returns responses, drives the
//            memory port, and with MEM_ACCESS_MMIO_EN also drives the MMIO port.
//   master : the surrounding pipeline, memory and MMIO view.
// Request : req_valid, req_ready, req_wr, req_size[2:0], req_addr[31:0], req_wdata[31:0]
// Response: rsp_valid, rsp_rdata[31:0], rsp_exc, rsp_exc_addr[31:0]
// Memory  : mem_addr[31:0], mem_data_in[31:0], mem_size[2:0], mem_wr, mem_en, mem_data_out[31:0]
// MMIO    : mmio_valid, mmio_wr, mmio_addr, mmio_wdata, mmio_size, mmio_ready, mmio_rdata
//           (present only when MEM_ACCESS_MMIO_EN is defined)
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [31:0] rsp_exc_addr;

    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [2:0]  mem_size;
    logic        mem_wr;
    logic        mem_en;
    logic [31:0] mem_data_out;

`ifdef MEM_ACCESS_MMIO_EN
    logic        mmio_valid;
    logic        mmio_wr;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [2:0]  mmio_size;
    logic        mmio_ready;
    logic [31:0] mmio_rdata;
`endif

    modport slave (
`ifdef MEM_ACCESS_MMIO_EN
        output mmio_valid, mmio_wr, mmio_addr, mmio_wdata, mmio_size,
        input  mmio_ready, mmio_rdata,
`endif
        input  req_valid, req_wr, req_size, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_exc, rsp_exc_addr,
        output mem_addr, mem_data_in, mem_size, mem_wr, mem_en,
        input  mem_data_out
    );

    modport master (
`ifdef MEM_ACCESS_MMIO_EN
        input  mmio_valid, mmio_wr, mmio_addr, mmio_wdata, mmio_size,
        output mmio_ready, mmio_rdata,
`endif
        output req_valid, req_wr, req_size, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_exc, rsp_exc_addr,
        input  mem_addr, mem_data_in, mem_size, mem_wr, mem_en,
        output mem_data_out
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of the SPRAM `memory` wrapper.
// It accepts one request at a time and checks size legality and alignment.
// It drives the memory port from registered request fields and absorbs the
// memory's one-cycle read latency. Each request produces exactly one registered
// response pulse.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous reset, active-high
//   bus : mem_access_unit_if.slave (request, response, memory and MMIO signals)
// Optional feature: define MEM_ACCESS_MMIO_EN to route legal accesses with
// addr[31:24] == 8'hFF to the MMIO port instead of memory.
module mem_access_unit (
    input logic            CLK,
    input logic            RST,
    mem_access_unit_if.slave bus
);

`ifdef MEM_ACCESS_MMIO_EN
    typedef enum logic [2:0] {IDLE, ISSUE, RD_CAPTURE, MMIO_WAIT, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, RD_CAPTURE, RESP} state_t;
`endif

    state_t      state_q, state_d;

    logic        wr_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rsp_rdata_q;
    logic        rsp_exc_q;
    logic [31:0] rsp_exc_addr_q;

    logic        fault;
    logic        is_mmio;
    logic        mem_en_c;
    logic        req_ready_c;
    logic        rsp_valid_c;

`ifdef MEM_ACCESS_MMIO_EN
    logic        mmio_valid_c;

    // Selects the addressed lane of an MMIO word and extends it. The memory
    // wrapper does this itself, but the MMIO side returns raw words.
    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  size);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            3'b000:  lane_extend = {{24{sh[7]}}, sh[7:0]};
            3'b001:  lane_extend = {{16{sh[15]}}, sh[15:0]};
            3'b100:  lane_extend = {24'h000000, sh[7:0]};
            3'b101:  lane_extend = {16'h0000, sh[15:0]};
            default: lane_extend = word;
        endcase
    endfunction
`endif

    // Legality of the registered request.
    always_comb begin
        fault = 1'b0;
        case (size_q)
            3'b011, 3'b110, 3'b111: fault = 1'b1;
            default: ;
        endcase
        if (wr_q && size_q[2]) fault = 1'b1;
        if (size_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) fault = 1'b1;
        if (size_q[1:0] == 2'b01 && addr_q[0]) fault = 1'b1;
    end

`ifdef MEM_ACCESS_MMIO_EN
    assign is_mmio = (addr_q[31:24] == 8'hFF);
`else
    assign is_mmio = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_c = 1'b0;
        mem_en_c    = 1'b0;
        rsp_valid_c = 1'b0;
`ifdef MEM_ACCESS_MMIO_EN
        mmio_valid_c = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_d = ISSUE;
            end
            ISSUE: begin
                if (fault) begin
                    state_d = RESP;
                end else if (is_mmio) begin
`ifdef MEM_ACCESS_MMIO_EN
                    state_d = MMIO_WAIT;
`endif
                end else begin
                    mem_en_c = 1'b1;
                    state_d  = wr_q ? RESP : RD_CAPTURE;
                end
            end
            RD_CAPTURE: state_d = RESP;
`ifdef MEM_ACCESS_MMIO_EN
            MMIO_WAIT: begin
                mmio_valid_c = 1'b1;
                if (bus.mmio_ready) state_d = RESP;
            end
`endif
            RESP: begin
                rsp_valid_c = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            wr_q           <= 1'b0;
            size_q         <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rsp_rdata_q    <= '0;
            rsp_exc_q      <= 1'b0;
            rsp_exc_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid) begin
                wr_q    <= bus.req_wr;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            // Response registers change only on the edge that enters RESP, so
            // they hold their values until the next response pulse.
            case (state_q)
                ISSUE: begin
                    if (fault || (wr_q && !is_mmio)) begin
                        rsp_rdata_q    <= '0;
                        rsp_exc_q      <= fault;
                        rsp_exc_addr_q <= addr_q;
                    end
                end
                RD_CAPTURE: begin
                    rsp_rdata_q    <= bus.mem_data_out;
                    rsp_exc_q      <= 1'b0;
                    rsp_exc_addr_q <= addr_q;
                end
`ifdef MEM_ACCESS_MMIO_EN
                MMIO_WAIT: begin
                    if (bus.mmio_ready) begin
                        rsp_rdata_q    <= wr_q ? '0 : lane_extend(bus.mmio_rdata, addr_q[1:0], size_q);
                        rsp_exc_q      <= 1'b0;
                        rsp_exc_addr_q <= addr_q;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.rsp_valid    = rsp_valid_c;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_exc      = rsp_exc_q;
    assign bus.rsp_exc_addr = rsp_exc_addr_q;

    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.mem_size    = size_q;
    // Gating with RST keeps a store caught in ISSUE from reaching memory.
    assign bus.mem_en      = mem_en_c & ~RST;
    assign bus.mem_wr      = mem_en_c & ~RST & wr_q;

`ifdef MEM_ACCESS_MMIO_EN
    assign bus.mmio_valid = mmio_valid_c;
    assign bus.mmio_wr    = wr_q;
    assign bus.mmio_addr  = addr_q;
    assign bus.mmio_wdata = wdata_q;
    assign bus.mmio_size  = size_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven bench for mem_access_unit, including a
// behavioural model of the `memory` SPRAM wrapper. The model has one-cycle read
// latency, per-size lane writes and extended reads. Hand-written sequences
// cover reset during ISSUE and MMIO routing.
module tb_mem_access_unit;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    // Memory model: 256 words, upper address bits ignored.
    logic [31:0] mem [0:255];

    function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] size);
        logic [31:0] sh;
        sh = w >> (off * 8);
        case (size)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge CLK) begin
        logic [31:0] w;
        logic [7:0]  idx;
        if (bus.mem_en) begin
            idx = bus.mem_addr[9:2];
            w   = mem[idx];
            if (bus.mem_wr) begin
                case (bus.mem_size[1:0])
                    2'b00:   w[bus.mem_addr[1:0]*8 +: 8]  = bus.mem_data_in[7:0];
                    2'b01:   w[bus.mem_addr[1]*16 +: 16] = bus.mem_data_in[15:0];
                    default: w = bus.mem_data_in;
                endcase
                mem[idx] <= w;
            end else begin
                bus.mem_data_out <= rd_ext(w, bus.mem_addr[1:0], bus.mem_size);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_exc;
        int unsigned exp_lat;
    } vec_t;

    function automatic vec_t mk(input string name, input logic wr, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_exc,
                                input int unsigned exp_lat);
        vec_t v;
        v.name = name; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_exc = exp_exc; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the response.
    task automatic do_req(input vec_t v);
        int unsigned n;
        logic seen_en, seen_wr, got;
        logic [31:0] held;
        check({v.name, " req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_wr    = v.wr;
        bus.req_size  = v.size;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check({v.name, " mem_addr"}, bus.mem_addr, v.addr);
        n = 1; seen_en = 1'b0; seen_wr = 1'b0; got = 1'b0;
        while (n <= 8) begin
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
            seen_en |= bus.mem_en;
            seen_wr |= bus.mem_wr;
            @(negedge CLK);
            n++;
        end
        if (!got) $display("FAIL %s timeout: no rsp_valid within 8 cycles", v.name);
        check({v.name, " latency"}, got ? n : 32'hFFFF_FFFF, v.exp_lat);
        check({v.name, " rdata"}, bus.rsp_rdata, v.exp_rdata);
        check({v.name, " exc"}, {31'b0, bus.rsp_exc}, {31'b0, v.exp_exc});
        if (v.exp_exc) check({v.name, " exc_addr"}, bus.rsp_exc_addr, v.addr);
        check({v.name, " mem_en seen"}, {31'b0, seen_en}, {31'b0, !v.exp_exc});
        check({v.name, " mem_wr seen"}, {31'b0, seen_wr}, {31'b0, v.wr && !v.exp_exc});
        held = bus.rsp_rdata;
        @(negedge CLK);
        check({v.name, " pulse end"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({v.name, " rdata hold"}, bus.rsp_rdata, held);
    endtask

`ifdef MEM_ACCESS_MMIO_EN
    task automatic mmio_load(input string name, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] rdata, input int unsigned delay,
                             input logic [31:0] exp);
        logic stray;
        bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_size = size;
        bus.req_addr = addr; bus.req_wdata = '0;
        bus.mmio_ready = 1'b0;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check({name, " mem_en"}, {31'b0, bus.mem_en}, 32'd0);
        @(negedge CLK);
        stray = 1'b0;
        for (int unsigned k = 0; k < delay; k++) begin
            check({name, " mmio_valid wait"}, {31'b0, bus.mmio_valid}, 32'd1);
            stray |= bus.rsp_valid | bus.mem_en;
            @(negedge CLK);
        end
        check({name, " mmio_valid"}, {31'b0, bus.mmio_valid}, 32'd1);
        check({name, " mmio_addr"}, bus.mmio_addr, addr);
        check({name, " no early rsp"}, {31'b0, stray}, 32'd0);
        bus.mmio_ready = 1'b1;
        bus.mmio_rdata = rdata;
        @(negedge CLK);
        bus.mmio_ready = 1'b0;
        check({name, " rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
        check({name, " rdata"}, bus.rsp_rdata, exp);
        @(negedge CLK);
    endtask
`endif

    initial begin
        vec_t vecs[$];
        logic stray;

        vecs.push_back(mk("sw100",  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2));
        vecs.push_back(mk("lw100",  1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 3));
        vecs.push_back(mk("sb101",  1'b1, 3'b000, 32'h101, 32'h80,       32'h0,        1'b0, 2));
        vecs.push_back(mk("lb101",  1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFF80, 1'b0, 3));
        vecs.push_back(mk("lbu101", 1'b0, 3'b100, 32'h101, 32'h0,        32'h00000080, 1'b0, 3));
        vecs.push_back(mk("lw100b", 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEAD80EF, 1'b0, 3));
        vecs.push_back(mk("lw102",  1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1, 2));
        vecs.push_back(mk("sh103",  1'b1, 3'b001, 32'h103, 32'hFFFF,     32'h0,        1'b1, 2));
        vecs.push_back(mk("lw100c", 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEAD80EF, 1'b0, 3));
        vecs.push_back(mk("lh102",  1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0, 3));
        vecs.push_back(mk("lhu102", 1'b0, 3'b101, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, 3));
        vecs.push_back(mk("ld011",  1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 2));
        vecs.push_back(mk("sbu100", 1'b1, 3'b100, 32'h100, 32'h11,       32'h0,        1'b1, 2));
        vecs.push_back(mk("ld111",  1'b0, 3'b111, 32'h100, 32'h0,        32'h0,        1'b1, 2));
        vecs.push_back(mk("sh102",  1'b1, 3'b001, 32'h102, 32'h1234,     32'h0,        1'b0, 2));
        vecs.push_back(mk("lw100d", 1'b0, 3'b010, 32'h100, 32'h0,        32'h123480EF, 1'b0, 3));
        vecs.push_back(mk("sw200",  1'b1, 3'b010, 32'h200, 32'h55AA55AA, 32'h0,        1'b0, 2));
        vecs.push_back(mk("sw004",  1'b1, 3'b010, 32'h004, 32'hCAFEF00D, 32'h0,        1'b0, 2));

        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.mem_data_out = '0;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
`ifdef MEM_ACCESS_MMIO_EN
        bus.mmio_ready = 1'b0; bus.mmio_rdata = '0;
`endif

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst rsp_exc", {31'b0, bus.rsp_exc}, 32'd0);
        check("rst rsp_exc_addr", bus.rsp_exc_addr, 32'd0);
        check("rst mem_en", {31'b0, bus.mem_en}, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);

        foreach (vecs[i]) do_req(vecs[i]);

        // Reset while SW 0x200 <- 1 sits in ISSUE.
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_size = 3'b010;
        bus.req_addr = 32'h200; bus.req_wdata = 32'h1;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("rstiss mem_en", {31'b0, bus.mem_en}, 32'd0);
        check("rstiss mem_wr", {31'b0, bus.mem_wr}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        check("rstiss req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rstiss outputs", bus.rsp_rdata | bus.rsp_exc_addr | bus.mem_addr | bus.mem_data_in |
              {29'b0, bus.mem_size} | {31'b0, bus.rsp_valid | bus.rsp_exc | bus.mem_en}, 32'd0);
        stray = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            stray |= bus.rsp_valid;
        end
        check("rstiss dropped rsp", {31'b0, stray}, 32'd0);
        do_req(mk("lw200", 1'b0, 3'b010, 32'h200, 32'h0, 32'h55AA55AA, 1'b0, 3));

`ifdef MEM_ACCESS_MMIO_EN
        mmio_load("mmio_lw", 32'hFF000004, 3'b010, 32'h12345678, 3, 32'h12345678);
        mmio_load("mmio_lb", 32'hFF000005, 3'b000, 32'h00008000, 0, 32'hFFFFFF80);
`else
        do_req(mk("lwFF", 1'b0, 3'b010, 32'hFF000004, 32'h0, 32'hCAFEF00D, 1'b0, 3));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
